// File: rtl/ysyx_23060332_wbu_pkg.sv
// ysyx_23060332_wbu_pkg: shared widths, types and helpers for the write-back slice
package ysyx_23060332_wbu_pkg;
    localparam int XLEN = 32;
    localparam int ADDR_W = 5;
    localparam int NR_REGS = 2 ** ADDR_W;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0] reg_data_t;
    localparam reg_addr_t ZERO_REG = '0;
    typedef enum logic [1:0] {SRC_NONE, SRC_EXU, SRC_LSU} wb_src_t;
    typedef struct packed {
        logic wen;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;
    function automatic logic writes_reg(input logic wen, input reg_addr_t rd);
        return wen && rd != ZERO_REG;
    endfunction
endpackage

// File: rtl/ysyx_23060332_wbu_if.sv
// ysyx_23060332_wbu_if: EXU/LSU result channels, IDU hazard queries and register-file write port
interface ysyx_23060332_wbu_if;
    import ysyx_23060332_wbu_pkg::*;
    logic exu_valid;
    logic exu_ready;
    reg_addr_t exu_rd;
    logic exu_wen;
    reg_data_t exu_data;
    logic lsu_valid;
    logic lsu_ready;
    reg_addr_t lsu_rd;
    reg_data_t lsu_data;
    logic issue_valid;
    reg_addr_t issue_rd;
    reg_addr_t rs1_q;
    reg_addr_t rs2_q;
    logic busy_rs1;
    logic busy_rs2;
    logic busy_rd;
    reg_addr_t waddr;
    reg_data_t wdata;
    logic reg_wen;
    logic [31:0] wb_count;
    modport slave (
        input exu_valid, exu_rd, exu_wen, exu_data, lsu_valid, lsu_rd, lsu_data,
        input issue_valid, issue_rd, rs1_q, rs2_q,
        output exu_ready, lsu_ready, busy_rs1, busy_rs2, busy_rd, waddr, wdata, reg_wen, wb_count
    );
    modport master (
        output exu_valid, exu_rd, exu_wen, exu_data, lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, rs1_q, rs2_q,
        input exu_ready, lsu_ready, busy_rs1, busy_rs2, busy_rd, waddr, wdata, reg_wen, wb_count
    );
endinterface

// File: rtl/ysyx_23060332_scoreboard.sv
// ysyx_23060332_scoreboard: per-register busy bits, set on issue, cleared on write-back, x0 never busy
module ysyx_23060332_scoreboard
    import ysyx_23060332_wbu_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic set_en,
    input reg_addr_t set_addr,
    input logic clr_en,
    input reg_addr_t clr_addr,
    input reg_addr_t rs1_addr,
    input reg_addr_t rs2_addr,
    input reg_addr_t rd_addr,
    output logic busy_rs1,
    output logic busy_rs2,
    output logic busy_rd
);
    logic [NR_REGS-1:0] busy;
    logic [NR_REGS-1:0] busy_nxt;
    logic [NR_REGS-1:0] set_mask;
    logic [NR_REGS-1:0] clr_mask;
    // Set is applied after clear so a same-edge re-issue keeps the register busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        set_mask[set_addr] = set_en;
        clr_mask[clr_addr] = clr_en;
        busy_nxt = ((busy & ~clr_mask) | set_mask) & {{(NR_REGS-1){1'b1}}, 1'b0};
    end
    always_ff @(posedge clk) begin
        busy <= rst ? '0 : busy_nxt;
    end
    always_ff @(posedge clk) begin
        if (!rst && set_en)
            assert (!busy[set_addr] || (clr_en && clr_addr == set_addr));
    end
    assign busy_rs1 = busy[rs1_addr];
    assign busy_rs2 = busy[rs2_addr];
    assign busy_rd = busy[rd_addr];
endmodule

// File: rtl/ysyx_23060332_wbu.sv
// ysyx_23060332_wbu: arbitrates LSU/EXU results onto the register-file write port and tracks busy registers
module ysyx_23060332_wbu
    import ysyx_23060332_wbu_pkg::*;
(
    input logic clk,
    input logic rst,
    ysyx_23060332_wbu_if.slave bus
);
    wb_src_t src;
    wb_req_t req;
    assign bus.lsu_ready = !rst;
    assign bus.exu_ready = !bus.lsu_valid && !rst;
    // LSU has fixed priority; EXU holds its result until LSU goes idle.
    always_comb begin
        src = (bus.lsu_valid && bus.lsu_ready) ? SRC_LSU : (bus.exu_valid && bus.exu_ready) ? SRC_EXU : SRC_NONE;
        req = (src == SRC_LSU) ? wb_req_t'{wen: writes_reg(1'b1, bus.lsu_rd), addr: bus.lsu_rd, data: bus.lsu_data}
                               : wb_req_t'{wen: writes_reg(bus.exu_wen, bus.exu_rd), addr: bus.exu_rd, data: bus.exu_data};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.reg_wen <= 1'b0;
            bus.waddr <= '0;
            bus.wdata <= '0;
            bus.wb_count <= '0;
        end else begin
            bus.reg_wen <= src != SRC_NONE && req.wen;
            if (src != SRC_NONE) begin
                bus.waddr <= req.addr;
                bus.wdata <= req.data;
            end
            bus.wb_count <= bus.wb_count + 32'(bus.reg_wen);
        end
    end
    ysyx_23060332_scoreboard u_scoreboard (
        .clk(clk),
        .rst(rst),
        .set_en(bus.issue_valid),
        .set_addr(bus.issue_rd),
        .clr_en(bus.reg_wen),
        .clr_addr(bus.waddr),
        .rs1_addr(bus.rs1_q),
        .rs2_addr(bus.rs2_q),
        .rd_addr(bus.issue_rd),
        .busy_rs1(bus.busy_rs1),
        .busy_rs2(bus.busy_rs2),
        .busy_rd(bus.busy_rd)
    );
endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// tb_ysyx_23060332_wbu: directed checks of arbitration, write-back timing, scoreboard and reset
module tb_ysyx_23060332_wbu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    ysyx_23060332_wbu_if bus();
    ysyx_23060332_wbu dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (bus.reg_wen !== 1'b0) begin errors++; $display("FAIL rst_reg_wen got %0h exp 0", bus.reg_wen); end
        checks++; if (bus.waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr got %0h exp 0", bus.waddr); end
        checks++; if (bus.wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %0h exp 0", bus.wdata); end
        checks++; if (bus.wb_count !== 32'd0) begin errors++; $display("FAIL rst_wb_count got %0d exp 0", bus.wb_count); end
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready got %0h exp 0", bus.lsu_ready); end
        checks++; if (bus.exu_ready !== 1'b0) begin errors++; $display("FAIL rst_exu_ready got %0h exp 0", bus.exu_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL post_rst_lsu_ready got %0h exp 1", bus.lsu_ready); end
    endtask

    task automatic test_exu_write();
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_wen = 1'b1; bus.exu_data = 32'hDEADBEEF;
        #1;
        checks++; if (bus.exu_ready !== 1'b1) begin errors++; $display("FAIL exu_ready got %0h exp 1", bus.exu_ready); end
        step();
        bus.exu_valid = 1'b0;
        checks++; if (bus.reg_wen !== 1'b1) begin errors++; $display("FAIL exu_reg_wen got %0h exp 1", bus.reg_wen); end
        checks++; if (bus.waddr !== 5'd5) begin errors++; $display("FAIL exu_waddr got %0d exp 5", bus.waddr); end
        checks++; if (bus.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL exu_wdata got %h exp deadbeef", bus.wdata); end
        step();
        checks++; if (bus.reg_wen !== 1'b0) begin errors++; $display("FAIL exu_idle_wen got %0h exp 0", bus.reg_wen); end
        checks++; if (bus.waddr !== 5'd5) begin errors++; $display("FAIL exu_hold_waddr got %0d exp 5", bus.waddr); end
        checks++; if (bus.wb_count !== 32'd1) begin errors++; $display("FAIL exu_wb_count got %0d exp 1", bus.wb_count); end
    endtask

    task automatic test_arbitration();
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd3; bus.exu_wen = 1'b1; bus.exu_data = 32'h3333_3333;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h4444_4444;
        #1;
        checks++; if (bus.exu_ready !== 1'b0) begin errors++; $display("FAIL arb_exu_ready got %0h exp 0", bus.exu_ready); end
        checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL arb_lsu_ready got %0h exp 1", bus.lsu_ready); end
        step();
        bus.lsu_valid = 1'b0;
        checks++; if (bus.reg_wen !== 1'b1 || bus.waddr !== 5'd4) begin errors++; $display("FAIL arb_lsu_first got wen=%0h waddr=%0d exp wen=1 waddr=4", bus.reg_wen, bus.waddr); end
        checks++; if (bus.wdata !== 32'h4444_4444) begin errors++; $display("FAIL arb_lsu_data got %h exp 44444444", bus.wdata); end
        #1;
        checks++; if (bus.exu_ready !== 1'b1) begin errors++; $display("FAIL arb_exu_ready_after got %0h exp 1", bus.exu_ready); end
        step();
        bus.exu_valid = 1'b0;
        checks++; if (bus.reg_wen !== 1'b1 || bus.waddr !== 5'd3) begin errors++; $display("FAIL arb_exu_second got wen=%0h waddr=%0d exp wen=1 waddr=3", bus.reg_wen, bus.waddr); end
        checks++; if (bus.wdata !== 32'h3333_3333) begin errors++; $display("FAIL arb_exu_data got %h exp 33333333", bus.wdata); end
        step();
        checks++; if (bus.wb_count !== 32'd3) begin errors++; $display("FAIL arb_wb_count got %0d exp 3", bus.wb_count); end
    endtask

    task automatic test_scoreboard();
        bus.rs1_q = 5'd7; bus.rs2_q = 5'd8;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        #1;
        checks++; if (bus.busy_rd !== 1'b0) begin errors++; $display("FAIL sb_rd_free got %0h exp 0", bus.busy_rd); end
        step();
        bus.issue_valid = 1'b0;
        #1;
        checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL sb_set got %0h exp 1", bus.busy_rs1); end
        checks++; if (bus.busy_rs2 !== 1'b0) begin errors++; $display("FAIL sb_other got %0h exp 0", bus.busy_rs2); end
        checks++; if (bus.busy_rd !== 1'b1) begin errors++; $display("FAIL sb_waw got %0h exp 1", bus.busy_rd); end
        step();
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_wen = 1'b1; bus.exu_data = 32'h0000_0777;
        step();
        bus.exu_valid = 1'b0;
        checks++; if (bus.reg_wen !== 1'b1 || bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL sb_busy_during_write got wen=%0h busy=%0h exp wen=1 busy=1", bus.reg_wen, bus.busy_rs1); end
        step();
        checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL sb_clear got %0h exp 0", bus.busy_rs1); end
        checks++; if (bus.wb_count !== 32'd4) begin errors++; $display("FAIL sb_wb_count got %0d exp 4", bus.wb_count); end
    endtask

    task automatic test_same_edge();
        bus.rs1_q = 5'd7;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        step();
        bus.issue_valid = 1'b0;
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd7; bus.exu_wen = 1'b1; bus.exu_data = 32'h7;
        step();
        bus.exu_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        step();
        bus.issue_valid = 1'b0;
        checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL same_edge_set_wins got %0h exp 1", bus.busy_rs1); end
        bus.exu_valid = 1'b1;
        step();
        bus.exu_valid = 1'b0;
        step();
        checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL same_edge_clear got %0h exp 0", bus.busy_rs1); end
        checks++; if (bus.wb_count !== 32'd6) begin errors++; $display("FAIL same_edge_wb_count got %0d exp 6", bus.wb_count); end
    endtask

    task automatic test_no_write();
        bus.exu_valid = 1'b1; bus.exu_rd = 5'd0; bus.exu_wen = 1'b1; bus.exu_data = 32'h1234;
        #1;
        checks++; if (bus.exu_ready !== 1'b1) begin errors++; $display("FAIL x0_exu_ready got %0h exp 1", bus.exu_ready); end
        step();
        checks++; if (bus.reg_wen !== 1'b0) begin errors++; $display("FAIL x0_reg_wen got %0h exp 0", bus.reg_wen); end
        bus.exu_rd = 5'd6; bus.exu_wen = 1'b0;
        step();
        bus.exu_valid = 1'b0;
        checks++; if (bus.reg_wen !== 1'b0) begin errors++; $display("FAIL nowen_reg_wen got %0h exp 0", bus.reg_wen); end
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h5555;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        step();
        bus.lsu_valid = 1'b0; bus.issue_valid = 1'b0;
        checks++; if (bus.reg_wen !== 1'b0) begin errors++; $display("FAIL lsu_x0_reg_wen got %0h exp 0", bus.reg_wen); end
        bus.rs2_q = 5'd0;
        step();
        checks++; if (bus.busy_rs2 !== 1'b0) begin errors++; $display("FAIL x0_busy got %0h exp 0", bus.busy_rs2); end
        checks++; if (bus.wb_count !== 32'd6) begin errors++; $display("FAIL nowrite_wb_count got %0d exp 6", bus.wb_count); end
    endtask

    task automatic test_reset_midflight();
        bus.rs1_q = 5'd9;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        step();
        bus.issue_valid = 1'b0;
        checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL mid_busy9 got %0h exp 1", bus.busy_rs1); end
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'hAAAA_AAAA;
        rst = 1'b1;
        #1;
        checks++; if (bus.lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_lsu_ready got %0h exp 0", bus.lsu_ready); end
        step();
        checks++; if (bus.reg_wen !== 1'b0) begin errors++; $display("FAIL mid_reg_wen got %0h exp 0", bus.reg_wen); end
        checks++; if (bus.waddr !== 5'd0) begin errors++; $display("FAIL mid_waddr got %0d exp 0", bus.waddr); end
        checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL mid_busy_cleared got %0h exp 0", bus.busy_rs1); end
        checks++; if (bus.wb_count !== 32'd0) begin errors++; $display("FAIL mid_wb_count got %0d exp 0", bus.wb_count); end
        rst = 1'b0;
        step();
        bus.lsu_valid = 1'b0;
        checks++; if (bus.reg_wen !== 1'b1 || bus.waddr !== 5'd10) begin errors++; $display("FAIL mid_resume got wen=%0h waddr=%0d exp wen=1 waddr=10", bus.reg_wen, bus.waddr); end
        checks++; if (bus.wdata !== 32'hAAAA_AAAA) begin errors++; $display("FAIL mid_resume_data got %h exp aaaaaaaa", bus.wdata); end
    endtask

    initial begin
        bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_wen = 1'b0; bus.exu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.rs1_q = '0; bus.rs2_q = '0;
        test_reset();
        test_exu_write();
        test_arbitration();
        test_scoreboard();
        test_same_edge();
        test_no_write();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
